// File: rtl/cache_bank_ctrl.sv
// cache_bank_ctrl: request sequencer in front of a 4-read / 1-write cache bank
// SRAM. Line writes are buffered in a small FIFO, 4-wide read bundles are
// accepted directly, and each cycle at most one of them is issued to the bank
// through registered CS/WE/RD/address/data pins. Read data returns two edges
// after acceptance with a per-port valid strobe.
//
// Optional macro WRITE_FORWARD_EN: reads compare their addresses against the
// queued writes and return the newest queued data instead of stale bank data.
// With the macro undefined, a read of an address that still has a queued write
// returns the old bank contents.

`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module cache_bank_ctrl #(
  parameter int ADR          = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int DAT          = `DATA_WIDTH,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         wrValid,
  output logic                         wrReady,
  input  logic [ADR-1:0]               wrAddr,
  input  logic [DAT-1:0]               wrData,
  input  logic [3:0]                   rdValid,
  input  logic [ADR-1:0]               rdAddr_0,
  input  logic [ADR-1:0]               rdAddr_1,
  input  logic [ADR-1:0]               rdAddr_2,
  input  logic [ADR-1:0]               rdAddr_3,
  output logic                         rdReady,
  output logic [3:0]                   rdDataValid,
  output logic [DAT-1:0]               rdData_0,
  output logic [DAT-1:0]               rdData_1,
  output logic [DAT-1:0]               rdData_2,
  output logic [DAT-1:0]               rdData_3,
  output logic                         ramCS,
  output logic                         ramWE,
  output logic                         ramRD,
  output logic [ADR-1:0]               ramWA,
  output logic [ADR-1:0]               ramRA_0,
  output logic [ADR-1:0]               ramRA_1,
  output logic [ADR-1:0]               ramRA_2,
  output logic [ADR-1:0]               ramRA_3,
  output logic [DAT-1:0]               ramDataIn,
  input  logic [DAT-1:0]               ramDout_0,
  input  logic [DAT-1:0]               ramDout_1,
  input  logic [DAT-1:0]               ramDout_2,
  input  logic [DAT-1:0]               ramDout_3,
  output logic [$clog2(WFIFO_DEPTH):0] wrCount
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(WFIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE} op_e;

  // Port bundles gathered into arrays so per-port logic can loop.
  logic [ADR-1:0] rd_addr  [4];
  logic [DAT-1:0] ram_dout [4];
  logic [ADR-1:0] ra_q     [4];
  logic [DAT-1:0] rd_data  [4];

  assign rd_addr[0]  = rdAddr_0;
  assign rd_addr[1]  = rdAddr_1;
  assign rd_addr[2]  = rdAddr_2;
  assign rd_addr[3]  = rdAddr_3;
  assign ram_dout[0] = ramDout_0;
  assign ram_dout[1] = ramDout_1;
  assign ram_dout[2] = ramDout_2;
  assign ram_dout[3] = ramDout_3;
  assign ramRA_0     = ra_q[0];
  assign ramRA_1     = ra_q[1];
  assign ramRA_2     = ra_q[2];
  assign ramRA_3     = ra_q[3];
  assign rdData_0    = rd_data[0];
  assign rdData_1    = rd_data[1];
  assign rdData_2    = rd_data[2];
  assign rdData_3    = rd_data[3];

  // Write FIFO storage and bookkeeping.
  logic [ADR-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DAT-1:0] fifo_data [WFIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           ready_en_q;
  logic [SW-1:0]  starve_q;
  logic           fifo_nonempty;
  logic           push;
  logic           pop;
  op_e            op;

  // Read pipeline: mask of the bundle held in the bank pins, then the mask
  // of the bundle whose data the bank is presenting this cycle.
  logic [3:0]     mask_q;
  logic [3:0]     ret_mask_q;

  assign fifo_nonempty = (count_q != '0);
  // wrReady stays low until the first edge after reset release.
  assign wrReady       = ready_en_q && (count_q < DEPTH_C);
  assign push          = wrValid && wrReady;
  assign wrCount       = count_q;
  assign rdDataValid   = ret_mask_q;

  // Arbitration: reads win unless a write has waited through STARVE_LIMIT reads.
  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_IDLE;
    if ((rdValid != 4'b0) && !(fifo_nonempty && (starve_q == LIMIT_C))) begin
      op = OP_READ;
    end else if (fifo_nonempty) begin
      op = OP_WRITE;
    end
  end

  assign pop     = (op == OP_WRITE);
  assign rdReady = (op == OP_READ);

  // FIFO pointers, occupancy and the post-reset ready enable.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO entry storage.
  // NOTE: the entry array has no reset; occupancy alone defines which entries are valid, and leaving it unreset lets it map to plain RAM/flops without reset fan-out.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= wrAddr;
      fifo_data[wr_ptr_q] <= wrData;
    end
  end

  // Starvation counter: counts reads granted over a pending write.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_q <= '0;
    end else if ((op == OP_READ) && fifo_nonempty) begin
      if (starve_q != LIMIT_C) starve_q <= starve_q + SW'(1);
    end else begin
      starve_q <= '0;
    end
  end

  // Bank pin registers loaded from this cycle's issue decision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ramCS     <= 1'b0;
      ramWE     <= 1'b0;
      ramRD     <= 1'b0;
      ramWA     <= '0;
      ramDataIn <= '0;
      mask_q    <= '0;
      for (int p = 0; p < 4; p++) ra_q[p] <= '0;
    end else begin
      unique case (op)
        OP_READ: begin
          ramCS  <= 1'b1;
          ramRD  <= 1'b1;
          ramWE  <= 1'b0;
          mask_q <= rdValid;
          for (int p = 0; p < 4; p++) ra_q[p] <= rd_addr[p];
        end
        OP_WRITE: begin
          ramCS     <= 1'b1;
          ramWE     <= 1'b1;
          ramRD     <= 1'b0;
          ramWA     <= fifo_addr[rd_ptr_q];
          ramDataIn <= fifo_data[rd_ptr_q];
        end
        default: begin
          ramCS <= 1'b0;
          ramWE <= 1'b0;
          ramRD <= 1'b0;
        end
      endcase
    end
  end

  // Return stage: the bank answers the bundle held in the pins one edge later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ret_mask_q <= '0;
    else        ret_mask_q <= ramRD ? mask_q : 4'b0;
  end

`ifdef WRITE_FORWARD_EN
  logic           fwd_hit   [4];
  logic [DAT-1:0] fwd_dat   [4];
  logic [3:0]     hit1_q;
  logic [3:0]     hit2_q;
  logic [DAT-1:0] fwd1_q    [4];
  logic [DAT-1:0] fwd2_q    [4];

  // Search queued writes oldest to newest so the newest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 4; p++) begin
      fwd_hit[p] = 1'b0;
      fwd_dat[p] = '0;
      for (int j = 0; j < WFIFO_DEPTH; j++) begin
        idx = rd_ptr_q + PW'(j);
        if ((CW'(j) < count_q) && (fifo_addr[idx] == rd_addr[p])) begin
          fwd_hit[p] = 1'b1;
          fwd_dat[p] = fifo_data[idx];
        end
      end
    end
  end

  // Forwarded data follows the read through the same two stages.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hit1_q <= '0;
      hit2_q <= '0;
      for (int p = 0; p < 4; p++) begin
        fwd1_q[p] <= '0;
        fwd2_q[p] <= '0;
      end
    end else begin
      if (op == OP_READ) begin
        for (int p = 0; p < 4; p++) begin
          hit1_q[p] <= fwd_hit[p];
          fwd1_q[p] <= fwd_dat[p];
        end
      end
      hit2_q <= hit1_q;
      for (int p = 0; p < 4; p++) fwd2_q[p] <= fwd1_q[p];
    end
  end

  // Return data: forwarded write data overrides the bank for hit ports.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_data[p] = '0;
      if (ret_mask_q[p]) rd_data[p] = hit2_q[p] ? fwd2_q[p] : ram_dout[p];
    end
  end
`else
  // Return data: bank output on strobed ports, zero elsewhere.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rd_data[p] = '0;
      if (ret_mask_q[p]) rd_data[p] = ram_dout[p];
    end
  end
`endif

endmodule

// File: tb/tb_cache_bank_ctrl.sv
// tb_cache_bank_ctrl: self-checking bench for cache_bank_ctrl. A bank model
// answers the DUT's pins; a transaction-level reference (queue of pending
// writes, memory image, queue of expected read returns) predicts every output
// each cycle. Directed scenarios pin the reference with literal values, then
// a randomized phase with occasional resets runs against the same reference.

module tb_cache_bank_ctrl;

  localparam int ADR   = 8;
  localparam int DAT   = 16;
  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic           Clk   = 1'b0;
  logic           Rst_n = 1'b1;
  logic           wrValid;
  logic           wrReady;
  logic [ADR-1:0] wrAddr;
  logic [DAT-1:0] wrData;
  logic [3:0]     rdValid;
  logic [ADR-1:0] rdAddr_0, rdAddr_1, rdAddr_2, rdAddr_3;
  logic           rdReady;
  logic [3:0]     rdDataValid;
  logic [DAT-1:0] rdData_0, rdData_1, rdData_2, rdData_3;
  logic           ramCS, ramWE, ramRD;
  logic [ADR-1:0] ramWA;
  logic [ADR-1:0] ramRA_0, ramRA_1, ramRA_2, ramRA_3;
  logic [DAT-1:0] ramDataIn;
  logic [DAT-1:0] ramDout_0, ramDout_1, ramDout_2, ramDout_3;
  logic [2:0]     wrCount;

  always #5 Clk = ~Clk;

  cache_bank_ctrl #(.ADR(ADR), .DAT(DAT), .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
    .rdValid(rdValid),
    .rdAddr_0(rdAddr_0), .rdAddr_1(rdAddr_1), .rdAddr_2(rdAddr_2), .rdAddr_3(rdAddr_3),
    .rdReady(rdReady), .rdDataValid(rdDataValid),
    .rdData_0(rdData_0), .rdData_1(rdData_1), .rdData_2(rdData_2), .rdData_3(rdData_3),
    .ramCS(ramCS), .ramWE(ramWE), .ramRD(ramRD), .ramWA(ramWA),
    .ramRA_0(ramRA_0), .ramRA_1(ramRA_1), .ramRA_2(ramRA_2), .ramRA_3(ramRA_3),
    .ramDataIn(ramDataIn),
    .ramDout_0(ramDout_0), .ramDout_1(ramDout_1), .ramDout_2(ramDout_2), .ramDout_3(ramDout_3),
    .wrCount(wrCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DAT-1:0] init_val(input int a);
    return 16'hC000 | DAT'(a & 255);
  endfunction

  // Bank model: registered reads, write lands one edge after the pins show it.
  logic [DAT-1:0] bank [256];
  bit bank_ready = 1'b0;
  always @(posedge Clk) begin
    if (!bank_ready) begin
      for (int i = 0; i < 256; i++) bank[i] <= init_val(i);
      bank_ready <= 1'b1;
    end else begin
      if (ramCS && ramWE) bank[ramWA] <= ramDataIn;
      if (ramCS && ramRD) begin
        ramDout_0 <= bank[ramRA_0];
        ramDout_1 <= bank[ramRA_1];
        ramDout_2 <= bank[ramRA_2];
        ramDout_3 <= bank[ramRA_3];
      end
    end
  end

  // Reference state.
  typedef struct packed {
    logic [ADR-1:0] a;
    logic [DAT-1:0] d;
  } wr_t;
  typedef struct packed {
    int                   due;
    logic [3:0]           mask;
    logic [3:0][DAT-1:0]  d;
  } ret_t;

  wr_t            q [$];
  ret_t           rq [$];
  logic [DAT-1:0] mem_m [256];
  int             starve;
  bit             ready_en;
  int             cyc;
  bit             pend_v;
  logic [ADR-1:0] pend_a;
  logic [DAT-1:0] pend_d;
  logic           e_cs, e_we, e_rd;
  logic [ADR-1:0] e_wa;
  logic [ADR-1:0] e_ra [4];
  logic [DAT-1:0] e_din;

  // What a read accepted now must return.
  function automatic logic [DAT-1:0] model_read(input logic [ADR-1:0] a);
    logic [DAT-1:0] v;
    v = mem_m[a];
`ifdef WRITE_FORWARD_EN
    foreach (q[k]) if (q[k].a == a) v = q[k].d;
`endif
    return v;
  endfunction

  // One clock: compare all outputs at the falling edge, then advance the model.
  task automatic step();
    bit         nonempty, grant, wissue, push;
    logic [3:0] exp_mask;
    ret_t       r;
    wr_t        w;
    r = '0;
    @(negedge Clk);
    nonempty = (q.size() != 0);
    grant    = (rdValid != 4'b0) && !(nonempty && (starve == LIM));
    wissue   = !grant && nonempty;
    push     = wrValid && ready_en && (q.size() < DEPTH);
    check("rdReady", rdReady, grant);
    check("wrReady", wrReady, ready_en && (q.size() < DEPTH));
    check("wrCount", wrCount, q.size());
    check("ramCS", ramCS, e_cs);
    check("ramWE", ramWE, e_we);
    check("ramRD", ramRD, e_rd);
    check("ramWA", ramWA, e_wa);
    check("ramDataIn", ramDataIn, e_din);
    check("ramRA_0", ramRA_0, e_ra[0]);
    check("ramRA_1", ramRA_1, e_ra[1]);
    check("ramRA_2", ramRA_2, e_ra[2]);
    check("ramRA_3", ramRA_3, e_ra[3]);
    exp_mask = 4'b0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      exp_mask = r.mask;
    end
    check("rdDataValid", rdDataValid, exp_mask);
    if (exp_mask[0]) check("rdData_0", rdData_0, r.d[0]);
    if (exp_mask[1]) check("rdData_1", rdData_1, r.d[1]);
    if (exp_mask[2]) check("rdData_2", rdData_2, r.d[2]);
    if (exp_mask[3]) check("rdData_3", rdData_3, r.d[3]);

    @(posedge Clk);
    cyc++;
    ready_en = 1'b1;
    if (pend_v) mem_m[pend_a] = pend_d;
    pend_v = 1'b0;
    if (grant) begin
      r.due  = cyc + 1;
      r.mask = rdValid;
      r.d[0] = model_read(rdAddr_0);
      r.d[1] = model_read(rdAddr_1);
      r.d[2] = model_read(rdAddr_2);
      r.d[3] = model_read(rdAddr_3);
      rq.push_back(r);
      e_cs = 1'b1; e_rd = 1'b1; e_we = 1'b0;
      e_ra[0] = rdAddr_0; e_ra[1] = rdAddr_1; e_ra[2] = rdAddr_2; e_ra[3] = rdAddr_3;
    end else if (wissue) begin
      w = q.pop_front();
      pend_v = 1'b1; pend_a = w.a; pend_d = w.d;
      e_cs = 1'b1; e_we = 1'b1; e_rd = 1'b0;
      e_wa = w.a; e_din = w.d;
    end else begin
      e_cs = 1'b0; e_we = 1'b0; e_rd = 1'b0;
    end
    starve = (grant && nonempty) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
    if (push) begin
      w.a = wrAddr;
      w.d = wrData;
      q.push_back(w);
    end
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once; release 1 ns after an edge.
  task automatic do_reset(input int hold);
    Rst_n = 1'b0;
    q.delete();
    rq.delete();
    starve = 0; ready_en = 1'b0; pend_v = 1'b0;
    e_cs = 1'b0; e_we = 1'b0; e_rd = 1'b0; e_wa = '0; e_din = '0;
    for (int p = 0; p < 4; p++) e_ra[p] = '0;
    #1;
    check("rst_ramCS", ramCS, 1'b0);
    check("rst_ramWE", ramWE, 1'b0);
    check("rst_ramRD", ramRD, 1'b0);
    check("rst_ramWA", ramWA, '0);
    check("rst_ramRA_0", ramRA_0, '0);
    check("rst_ramDataIn", ramDataIn, '0);
    check("rst_rdDataValid", rdDataValid, 4'b0);
    check("rst_rdData_0", rdData_0, '0);
    check("rst_wrCount", wrCount, 3'd0);
    check("rst_wrReady", wrReady, 1'b0);
    repeat (hold) @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    wrValid = 1'b0; rdValid = 4'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 16 && q.size() != 0; i++) step();
    step();
    step();
  endtask

  logic [13:0] pat;

  initial begin
    wrValid = 1'b0; wrAddr = '0; wrData = '0; rdValid = 4'b0;
    rdAddr_0 = '0; rdAddr_1 = '0; rdAddr_2 = '0; rdAddr_3 = '0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = init_val(i);
    #2;
    do_reset(3);

    // wrReady rises one cycle after release.
    check("tp_wrready_after_release", wrReady, 1'b0);
    step();
    check("tp_wrready_next_cycle", wrReady, 1'b1);

    // Single write: push, then issue to the bank.
    wrValid = 1'b1; wrAddr = 8'd5; wrData = 16'h00A5;
    step();
    wrValid = 1'b0;
    step();
    check("tp_write_we", ramWE, 1'b1);
    check("tp_write_cs", ramCS, 1'b1);
    check("tp_write_wa", ramWA, 8'd5);
    check("tp_write_din", ramDataIn, 16'h00A5);
    check("tp_write_count", wrCount, 3'd0);

    // Read bundle on ports 0 and 2 sees the write.
    rdValid = 4'b0101; rdAddr_0 = 8'd5; rdAddr_2 = 8'd5;
    #1 check("tp_read_ready", rdReady, 1'b1);
    step();
    rdValid = 4'b0;
    step();
    check("tp_read_valid", rdDataValid, 4'b0101);
    check("tp_read_data0", rdData_0, 16'h00A5);
    check("tp_read_data2", rdData_2, 16'h00A5);
    drain();

    // Fill the FIFO under continuous 4-wide reads: 3 reads per write.
    rdValid = 4'b1111;
    rdAddr_0 = 8'h30; rdAddr_1 = 8'h31; rdAddr_2 = 8'h32; rdAddr_3 = 8'h33;
    wrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wrAddr = ADR'(8'h20 + i);
      wrData = DAT'(16'h1000 + i);
      step();
    end
    check("tp_full_count", wrCount, 3'd4);
    check("tp_full_ready", wrReady, 1'b0);
    pat = 14'b10111011101110;
    for (int k = 0; k < 14; k++) begin
      if (k == 1) wrValid = 1'b0;
      #1 check("tp_starve_pattern", rdReady, pat[k]);
      step();
      if (k == 0) check("tp_full_no_push", wrCount, 3'd3);
    end
    drain();

    // Simultaneous push and pop at occupancy 2.
    rdValid = 4'b1111; wrValid = 1'b1;
    wrAddr = 8'h40; wrData = 16'h4040;
    step();
    wrAddr = 8'h41; wrData = 16'h4141;
    step();
    check("tp_pushpop_before", wrCount, 3'd2);
    rdValid = 4'b0; wrAddr = 8'h42; wrData = 16'h4242;
    step();
    check("tp_pushpop_after", wrCount, 3'd2);
    drain();

    // Queued write to address 9 while reads of address 9 keep winning.
    rdValid = 4'b0001; rdAddr_0 = 8'd9;
    wrValid = 1'b1; wrAddr = 8'd9; wrData = 16'h0011;
    step();
    wrValid = 1'b0;
    step();
    step();
    step();
    check("tp_hazard_valid", rdDataValid, 4'b0001);
`ifdef WRITE_FORWARD_EN
    check("tp_hazard_data", rdData_0, 16'h0011);
`else
    check("tp_hazard_data", rdData_0, 16'hC009);
`endif
    drain();

    // Reset in the cycle after a read grant drops the in-flight read.
    rdValid = 4'b1111;
    rdAddr_0 = 8'd1; rdAddr_1 = 8'd2; rdAddr_2 = 8'd3; rdAddr_3 = 8'd4;
    #1 check("tp_rst_grant", rdReady, 1'b1);
    step();
    idle_inputs();
    do_reset(2);
    step();
    step();
    check("tp_rst_no_return", rdDataValid, 4'b0);
    step();

    // Randomized traffic over a small address range with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      wrValid  = 1'($urandom_range(0, 1));
      wrAddr   = ADR'($urandom_range(0, 15));
      wrData   = DAT'($urandom);
      rdValid  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      rdAddr_0 = ADR'($urandom_range(0, 15));
      rdAddr_1 = ADR'($urandom_range(0, 15));
      rdAddr_2 = ADR'($urandom_range(0, 15));
      rdAddr_3 = ADR'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) do_reset(2);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_bank_ctrl.md
Name: cache_bank_ctrl

Overview:
Request sequencer placed directly upstream of the cache bank SRAM (4 read ports, 1 write port, registered outputs, read and write mutually exclusive per cycle). It buffers incoming line writes in a small FIFO and accepts 4-wide read bundles. Each cycle it arbitrates between one read bundle and one buffered write, drives the bank's CS/WE/RD/address/data pins from registers, and returns read data with per-port valid strobes. The cache lookup logic sits upstream of this block.

Parameters:
ADR, `CACHE_BANK_ADDRESS_WIDTH, bank address width
DAT, `DATA_WIDTH, data word width
WFIFO_DEPTH, 4, write FIFO entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive read grants allowed while a write is pending

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
wrValid  input  1  write request
wrReady  output  1  write FIFO can accept
wrAddr  input  ADR  write line address
wrData  input  DAT  write data
rdValid  input  4  per-port read request bundle
rdAddr_0..rdAddr_3  input  ADR each  read addresses
rdReady  output  1  read bundle granted this cycle
rdDataValid  output  4  per-port read data strobe
rdData_0..rdData_3  output  DAT each  read data
ramCS, ramWE, ramRD  output  1 each  bank controls (registered)
ramWA  output  ADR  bank write address (registered)
ramRA_0..ramRA_3  output  ADR each  bank read addresses (registered)
ramDataIn  output  DAT  bank write data (registered)
ramDout_0..ramDout_3  input  DAT each  bank read data
wrCount  output  log2(WFIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (Rst_n low, async): FIFO empty, wrCount=0, starve counter=0, all ram* outputs=0, rdDataValid=0, rdData=0, wrReady=0. wrReady rises one cycle after release. Any in-flight read is dropped: no rdDataValid follows.
- Write accept: wrValid&&wrReady at an edge pushes {wrAddr,wrData}. wrReady = (wrCount<WFIFO_DEPTH), based on occupancy before any same-cycle pop. A full FIFO does not accept, even when it is popping that edge.
- Arbitration, evaluated combinationally each cycle:
  - Read grant: rdValid!=0 and NOT (FIFO non-empty and starve==STARVE_LIMIT). When granted, rdReady=1.
  - Write issue: no read grant and FIFO non-empty pops the head entry.
  - Otherwise idle.
- Issue registers, updated at the edge:
  - READ: ramCS=1, ramRD=1, ramWE=0, ramRA_i=rdAddr_i. The rdValid mask is stored.
  - WRITE: ramCS=1, ramWE=1, ramRD=0, ramWA/ramDataIn = head entry.
  - IDLE: ramCS=ramWE=ramRD=0. Address and data registers hold.
- Starve counter: increments on a read grant while the FIFO is non-empty (saturates at STARVE_LIMIT). Clears on a write issue or when the FIFO is empty.
- Read latency: bundle accepted at edge E0; bank samples at E1. During the cycle after E1, rdDataValid = stored mask for exactly one cycle and rdData_i = ramDout_i. rdData_i for unmasked ports is don't-care.
- Back-to-back read grants give one bundle per cycle, fully pipelined.
- Ordering: writes are issued in FIFO order. A write issued at E-1 is visible to a read issued at E0.
- wrCount: updates every edge, push +1 and pop -1; simultaneous push and pop leaves it unchanged.

Optional Feature:
WRITE_FORWARD_EN
- Defined: at read acceptance (E0), each port's address is compared against all valid FIFO entries. The newest match's data is captured into a forward register plus a hit bit. During the return cycle, hit ports output the forwarded data instead of ramDout_i. Reads therefore always observe every write accepted before them.
- Undefined: no comparators. Reads return bank contents, so a read of an address with a still-queued write returns stale data (documented hazard).

Test Plan:
- Reset release, then wrValid with addr 5 / data 0xA5 -> push; next cycle ramWE=1, ramWA=5, ramDataIn=0xA5; wrCount returns to 0.
- After the above, rdValid=4'b0101, rdAddr_0=5, rdAddr_2=5 -> rdReady=1; two edges later rdDataValid=4'b0101, rdData_0=rdData_2=0xA5.
- Fill 4 writes while rdValid=4'b1111 is held continuously -> wrReady=0 with wrCount=4; exactly 3 read grants, then 1 write issue, repeating until FIFO empty.
- Write addr 9 data 0x11 queued while a continuous read of addr 9 is granted -> without the macro, first read returns old data; with WRITE_FORWARD_EN, returns 0x11.
- Assert Rst_n low in the cycle after a read grant -> no rdDataValid, all ram* outputs 0 immediately, wrCount=0.
- Simultaneous push and pop at wrCount=2 -> wrCount stays 2; at wrCount=4, wrReady=0 and no push occurs.
